// File: rtl/fp_add_hs.sv
// fp_add_hs: handshaked multi-cycle IEEE-754 adder/subtractor, RNE rounding, {invalid, overflow, inexact} flags.
// Define FP_ADD_DENORM_EN for full subnormal support; otherwise subnormal inputs and results flush to zero.
module fp_add_hs #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [EXP_W+FRAC_W:0] in_a,
  input  logic [EXP_W+FRAC_W:0] in_b,
  input  logic                  in_sub,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [EXP_W+FRAC_W:0] out_z,
  output logic [2:0]            out_flags,
  output logic                  out_valid,
  input  logic                  out_ready
);
  localparam int W  = EXP_W + FRAC_W + 1;
  localparam int MW = FRAC_W + 4;  // hidden, fraction, guard, round, sticky
  localparam int EW = EXP_W + 2;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE, S_UNPACK, S_SPECIAL, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_PACK, S_OUT
  } state_t;

  state_t        state_q;
  logic [W-1:0]  a_q, b_q, z_q;
  logic          sub_q, sa_q, sb_q, s_q, spec_q, in_ready_q, out_valid_q;
  logic [EW-1:0] ea_q, eb_q, e_q;
  logic [MW-1:0] ma_q, mb_q, m_q;
  logic [2:0]    flags_q;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_z     = z_q;
  assign out_flags = flags_q;

  logic [EXP_W-1:0]  a_exp, b_exp;
  logic [FRAC_W-1:0] a_frac, b_frac;
  assign a_exp  = a_q[W-2:FRAC_W];
  assign b_exp  = b_q[W-2:FRAC_W];
  assign a_frac = a_q[FRAC_W-1:0];
  assign b_frac = b_q[FRAC_W-1:0];

  // Unpack: exp field 0 behaves as exp 1
  logic [EW-1:0] ea_d, eb_d;
  logic [MW-1:0] ma_d, mb_d;
  always_comb begin
    ea_d = (a_exp == '0) ? EW'(1) : {2'b00, a_exp};
    eb_d = (b_exp == '0) ? EW'(1) : {2'b00, b_exp};
`ifdef FP_ADD_DENORM_EN
    ma_d = {|a_exp, a_frac, 3'b000};
    mb_d = {|b_exp, b_frac, 3'b000};
`else
    ma_d = (a_exp == '0) ? '0 : {1'b1, a_frac, 3'b000};
    mb_d = (b_exp == '0) ? '0 : {1'b1, b_frac, 3'b000};
`endif
  end

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, is_spec_d, inv_d;
  logic [W-1:0] spz_d;
  assign a_nan  = (&a_exp) & (|a_frac);
  assign b_nan  = (&b_exp) & (|b_frac);
  assign a_inf  = (&a_exp) & ~(|a_frac);
  assign b_inf  = (&b_exp) & ~(|b_frac);
  assign a_zero = (ma_q == '0);
  assign b_zero = (mb_q == '0);
  assign is_spec_d = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

  always_comb begin
    spz_d = '0;
    inv_d = 1'b0;
    if (a_nan || b_nan) begin
      spz_d = QNAN;
    end else if (a_inf && b_inf && (sa_q != sb_q)) begin
      spz_d = QNAN;
      inv_d = 1'b1;
    end else if (a_inf) begin
      spz_d = {sa_q, EXP_ONES, {FRAC_W{1'b0}}};
    end else if (b_inf) begin
      spz_d = {sb_q, EXP_ONES, {FRAC_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      spz_d = {sa_q & sb_q, {(W-1){1'b0}}};
    end else if (a_zero) begin
      spz_d = {sb_q, b_q[W-2:0]};
    end else if (b_zero) begin
      spz_d = {sa_q, a_q[W-2:0]};
    end
  end

  logic              a_big;
  logic [EW-1:0]     diff_d, sh_amt;
  logic [MW-1:0]     small_d, algn_d;
  logic [2*MW-1:0]   sh_d;
  always_comb begin
    a_big   = (ea_q >= eb_q);
    diff_d  = a_big ? (ea_q - eb_q) : (eb_q - ea_q);
    sh_amt  = (diff_d > EW'(MW)) ? EW'(MW) : diff_d;
    small_d = a_big ? mb_q : ma_q;
    sh_d    = {small_d, {MW{1'b0}}} >> sh_amt;
    // everything shifted past bit 0 folds into sticky
    algn_d  = {sh_d[2*MW-1:MW+1], sh_d[MW] | (|sh_d[MW-1:0])};
  end

  logic          eff_sub, ma_ge, sgn_d;
  logic [MW:0]   sum_d;
  always_comb begin
    eff_sub = sa_q ^ sb_q;
    ma_ge   = (ma_q >= mb_q);
    if (!eff_sub)   sum_d = {1'b0, ma_q} + {1'b0, mb_q};
    else if (ma_ge) sum_d = {1'b0, ma_q - mb_q};
    else            sum_d = {1'b0, mb_q - ma_q};
    sgn_d = (eff_sub && !ma_ge) ? sb_q : sa_q;
    if (sum_d == '0) sgn_d = 1'b0;
  end

  logic              rup_d;
  logic [FRAC_W+1:0] rnd_d;
  always_comb begin
    rup_d = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
    rnd_d = {1'b0, m_q[MW-1:3]} + {{(FRAC_W+1){1'b0}}, rup_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      z_q         <= '0;
      sub_q       <= 1'b0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      s_q         <= 1'b0;
      spec_q      <= 1'b0;
      ea_q        <= '0;
      eb_q        <= '0;
      e_q         <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      m_q         <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          a_q        <= in_a;
          b_q        <= in_b;
          sub_q      <= in_sub;
          flags_q    <= '0;
          in_ready_q <= 1'b0;
          state_q    <= S_UNPACK;
        end
        S_UNPACK: begin
          sa_q    <= a_q[W-1];
          sb_q    <= b_q[W-1] ^ sub_q;
          ea_q    <= ea_d;
          eb_q    <= eb_d;
          ma_q    <= ma_d;
          mb_q    <= mb_d;
          state_q <= S_SPECIAL;
        end
        S_SPECIAL: begin
          spec_q <= is_spec_d;
          if (is_spec_d) begin
            z_q        <= spz_d;
            flags_q[2] <= inv_d;
            state_q    <= S_PACK;
          end else begin
            state_q <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          // larger operand ends up in the a slot, aligned one in b
          ma_q    <= a_big ? ma_q : mb_q;
          sa_q    <= a_big ? sa_q : sb_q;
          mb_q    <= algn_d;
          sb_q    <= a_big ? sb_q : sa_q;
          e_q     <= a_big ? ea_q : eb_q;
          state_q <= S_ADD;
        end
        S_ADD: begin
          s_q     <= sgn_d;
          m_q     <= sum_d[MW] ? {sum_d[MW:2], sum_d[1] | sum_d[0]} : sum_d[MW-1:0];
          e_q     <= e_q + {{(EW-1){1'b0}}, sum_d[MW]};
          state_q <= S_NORM;
        end
        S_NORM: begin
          if (!m_q[MW-1] && (m_q != '0) && (e_q > EW'(1))) begin
            m_q <= {m_q[MW-2:0], m_q[0]};
            e_q <= e_q - EW'(1);
          end else begin
            state_q <= S_ROUND;
          end
        end
        S_ROUND: begin
          flags_q[0] <= m_q[2] | m_q[1] | m_q[0];
          if (rnd_d[FRAC_W+1]) begin
            m_q <= {rnd_d[FRAC_W+1:1], 3'b000};
            e_q <= e_q + EW'(1);
          end else begin
            m_q <= {rnd_d[FRAC_W:0], 3'b000};
          end
          state_q <= S_PACK;
        end
        S_PACK: begin
          if (!spec_q) begin
            if (e_q >= {2'b00, EXP_ONES}) begin
              z_q        <= {s_q, EXP_ONES, {FRAC_W{1'b0}}};
              flags_q[1] <= 1'b1;
              flags_q[0] <= 1'b1;
            end else if (!m_q[MW-1]) begin
`ifdef FP_ADD_DENORM_EN
              z_q <= {s_q, {EXP_W{1'b0}}, m_q[MW-2:3]};
`else
              z_q <= {s_q, {(W-1){1'b0}}};
              if (m_q != '0) flags_q[0] <= 1'b1;
`endif
            end else begin
              z_q <= {s_q, e_q[EXP_W-1:0], m_q[MW-2:3]};
            end
          end
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_hs.sv
// Scoreboard bench for fp_add_hs: directed binary32 vectors, backpressure, mid-op reset, binary64 instance.
module tb_fp_add_hs;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] in_a = '0, in_b = '0, out_z;
  logic        in_sub = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [2:0]  out_flags;

  logic [63:0] a64 = '0, b64 = '0, z64;
  logic        sub64 = 1'b0, iv64 = 1'b0, or64 = 1'b1;
  logic        ir64, ov64;
  logic [2:0]  f64;

  fp_add_hs dut (
    .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .in_valid(in_valid), .in_ready(in_ready), .out_z(out_z), .out_flags(out_flags),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  fp_add_hs #(.EXP_W(11), .FRAC_W(52)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_a(a64), .in_b(b64), .in_sub(sub64),
    .in_valid(iv64), .in_ready(ir64), .out_z(z64), .out_flags(f64),
    .out_valid(ov64), .out_ready(or64)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  logic [34:0] sbq[$];
  logic [66:0] sbq64[$];
  logic [34:0] e32;
  logic [66:0] e64;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out: got %h", out_z);
      end else begin
        e32 = sbq.pop_front();
        chk($sformatf("out%0d_z", n_out), {32'h0, out_z}, {32'h0, e32[34:3]});
        chk($sformatf("out%0d_flags", n_out), {61'h0, out_flags}, {61'h0, e32[2:0]});
      end
      n_out++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov64 && or64) begin
      if (sbq64.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out64: got %h", z64);
      end else begin
        e64 = sbq64.pop_front();
        chk("b64_z", z64, e64[66:3]);
        chk("b64_flags", {61'h0, f64}, {61'h0, e64[2:0]});
      end
    end
  end

`ifdef FP_ADD_DENORM_EN
  localparam logic [31:0] DN_Z = 32'h00000002;
`else
  localparam logic [31:0] DN_Z = 32'h00000000;
`endif

  localparam int NV = 15;
  logic [31:0] VA [NV] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7F800000, 32'h7FC00001,
                           32'h7F7FFFFF, 32'h3F800000, 32'h3F800001, 32'h80000000, 32'h00000000,
                           32'h7F800000, 32'h3F800000, 32'h00000001, 32'h3F800000, 32'h7F800000};
  logic [31:0] VB [NV] = '{32'h40000000, 32'h40000000, 32'h3F800000, 32'hFF800000, 32'h3F800000,
                           32'h7F7FFFFF, 32'h33800000, 32'h33800000, 32'h80000000, 32'h3F800000,
                           32'h3F800000, 32'h3F7FFFFF, 32'h00000001, 32'h00800000, 32'h7F800000};
  logic        VS [NV] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                           1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [31:0] VZ [NV] = '{32'h40400000, 32'hBF800000, 32'h00000000, 32'h7FC00000, 32'h7FC00000,
                           32'h7F800000, 32'h3F800000, 32'h3F800002, 32'h80000000, 32'hBF800000,
                           32'h7F800000, 32'h33800000, DN_Z,         32'h3F800000, 32'h7FC00000};
  logic [2:0]  VF [NV] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b000,
                           3'b011, 3'b001, 3'b001, 3'b000, 3'b000,
                           3'b000, 3'b000, 3'b000, 3'b001, 3'b100};

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic [31:0] z, input logic [2:0] f, input bit push);
    int n = 0;
    while (!in_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready %b, expected 1", in_ready);
    end
    in_a = a;
    in_b = b;
    in_sub = sub;
    in_valid = 1'b1;
    if (push) sbq.push_back({z, f});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || sbq64.size() != 0) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  logic [31:0] zc;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_out_z", {32'h0, out_z}, 64'h0);
    chk("rst_out_flags", {61'h0, out_flags}, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) send(VA[i], VB[i], VS[i], VZ[i], VF[i], 1'b1);
    drain();

    // Backpressure: result must hold while stray in_valid pulses are ignored
    out_ready = 1'b0;
    send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 1'b1);
    for (int n = 0; n < 100 && !out_valid; n++) begin
      @(posedge clk); #1;
    end
    chk("bp_valid_seen", {63'h0, out_valid}, 64'h1);
    zc = out_z;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid = i[0];
      in_a = $urandom;
      in_b = $urandom;
      chk("bp_z_stable", {32'h0, out_z}, {32'h0, zc});
      chk("bp_in_ready", {63'h0, in_ready}, 64'h0);
      chk("bp_out_valid", {63'h0, out_valid}, 64'h1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 3'b000, 1'b1);
    drain();

    // Reset during the long normalise of 1.0 - (1.0 - ulp)
    send(32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h0, 3'b000, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", {63'h0, in_ready}, 64'h1);
    chk("mid_rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("mid_rst_out_z", {32'h0, out_z}, 64'h0);
    chk("mid_rst_out_flags", {61'h0, out_flags}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 1'b1);
    drain();

    // binary64 instance
    for (int n = 0; n < 100 && !ir64; n++) begin
      @(posedge clk); #1;
    end
    a64 = 64'h3FF0000000000000;
    b64 = 64'h4000000000000000;
    sub64 = 1'b0;
    iv64 = 1'b1;
    sbq64.push_back({64'h4008000000000000, 3'b000});
    @(posedge clk); #1;
    iv64 = 1'b0;
    drain();

    chk("sb_empty", 64'(sbq.size()), 64'h0);
    chk("sb64_empty", 64'(sbq64.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
